// File: rtl/mmio_interconnect_if.sv
// Bus bundle between the CPU memory port, the interconnect and the MMIO slaves.
// "master" is the environment view (CPU + slaves); "slave" is the interconnect view.
interface mmio_interconnect_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic                       m_req;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic [DATA_W/8-1:0]        m_byteMask;
    logic                       m_write;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_ready;
    logic                       m_err;
    logic [N_SLAVES-1:0]        s_req;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic [DATA_W/8-1:0]        s_byteMask;
    logic                       s_write;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;
    logic [N_SLAVES-1:0]        s_ready;
    logic [ADDR_W-1:0]          err_addr;
    logic [7:0]                 err_count;

    modport master (
        output m_req, m_addr, m_wdata, m_byteMask, m_write, s_rdata, s_ready,
        input  m_rdata, m_ready, m_err, s_req, s_addr, s_wdata, s_byteMask, s_write,
               err_addr, err_count
    );

    modport slave (
        input  m_req, m_addr, m_wdata, m_byteMask, m_write, s_rdata, s_ready,
        output m_rdata, m_ready, m_err, s_req, s_addr, s_wdata, s_byteMask, s_write,
               err_addr, err_count
    );
endinterface

// File: rtl/mmio_interconnect.sv
// MMIO interconnect: address decode, per-slave wait states, watchdog timeout,
// bus-error response with sticky error address and saturating error count.
module mmio_interconnect #(
    parameter int                         N_SLAVES = 4,
    parameter int                         ADDR_W   = 32,
    parameter int                         DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
    parameter int                         TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    mmio_interconnect_if.slave  bus
);
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, MISS} state_t;

    state_t              r_state, w_next;
    logic [SEL_W-1:0]    r_sel, w_hit_idx;
    logic                w_hit;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr, r_err_addr;
    logic [7:0]          r_err_count;
    logic                w_ready, w_err, w_sel_ready, w_timeout;
    logic [DATA_W-1:0]   w_rdata;
    logic [N_SLAVES-1:0] w_sreq;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((bus.m_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[k*ADDR_W +: ADDR_W] & SLV_MASK[k*ADDR_W +: ADDR_W])) begin
                w_hit     = 1'b1;
                w_hit_idx = SEL_W'(k);
            end
        end
    end

    assign w_sel_ready = bus.s_ready[r_sel];
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT)) && !w_sel_ready;

    always_comb begin
        w_next  = r_state;
        w_sreq  = '0;
        w_ready = 1'b0;
        w_err   = 1'b0;
        w_rdata = '0;
        case (r_state)
            IDLE: begin
                if (bus.m_req) begin
                    if (w_hit) begin
                        w_sreq[w_hit_idx] = 1'b1;
                        w_next            = WAIT;
                    end else begin
                        w_next = MISS;
                    end
                end
            end
            WAIT: begin
                w_rdata = bus.s_rdata[r_sel*DATA_W +: DATA_W];
                if (w_sel_ready) begin
                    w_ready = 1'b1;
                    w_next  = IDLE;
                end else if (w_timeout) begin
                    // Abandon the slave; any later s_ready lands outside WAIT.
                    w_ready = 1'b1;
                    w_err   = 1'b1;
                    w_rdata = '0;
                    w_next  = IDLE;
                end
            end
            MISS: begin
                w_ready = 1'b1;
                w_err   = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.m_req) begin
                r_addr <= bus.m_addr;
                r_sel  <= w_hit_idx;
                r_cnt  <= '0;
            end else if (r_state == WAIT && !w_sel_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ready && w_err) begin
                r_err_addr <= r_addr;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.s_req      = w_sreq;
    assign bus.m_ready    = w_ready;
    assign bus.m_err      = w_err;
    assign bus.m_rdata    = w_rdata;
    assign bus.s_addr     = bus.m_addr;
    assign bus.s_wdata    = bus.m_wdata;
    assign bus.s_byteMask = bus.m_byteMask;
    assign bus.s_write    = bus.m_write;
    assign bus.err_addr   = r_err_addr;
    assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect: two slaves, TIMEOUT=4.
module tb_mmio_interconnect;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mmio_interconnect_if #(.N_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus ();

    mmio_interconnect #(
        .N_SLAVES(2), .ADDR_W(32), .DATA_W(32),
        .SLV_BASE({32'hFFFF_FFF0, 32'h0000_0000}),
        .SLV_MASK({32'hFFFF_FFFC, 32'hFFFF_FE00}),
        .TIMEOUT(4)
    ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.m_req = 0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_byteMask = '0; bus.m_write = 0;
        bus.s_rdata = {32'h1234_5678, 32'hDEAD_BEEF}; bus.s_ready = 2'b00;
        reset_n = 0; tick(); tick(); reset_n = 1; smp();
        n_chk++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_ready got %0b exp 0", bus.m_ready); end
        n_chk++; if (bus.m_err !== 1'b0) begin n_fail++; $display("FAIL reset_m_err got %0b exp 0", bus.m_err); end
        n_chk++; if (bus.m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m_rdata got %h exp 0", bus.m_rdata); end
        n_chk++; if (bus.s_req !== 2'b00) begin n_fail++; $display("FAIL reset_s_req got %b exp 00", bus.s_req); end
        n_chk++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d exp 0", bus.err_count); end
        n_chk++; if (bus.err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err_addr got %h exp 0", bus.err_addr); end
    endtask

    task automatic test_read_bram();
        tick(); bus.s_ready = 2'b01; bus.m_req = 1; bus.m_addr = 32'h0000_0040; bus.m_write = 0; smp();
        n_chk++; if (bus.s_req !== 2'b01) begin n_fail++; $display("FAIL rd_s_req got %b exp 01", bus.s_req); end
        n_chk++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_T got %0b exp 0", bus.m_ready); end
        n_chk++; if (bus.s_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL rd_s_addr got %h exp 00000040", bus.s_addr); end
        tick(); smp();
        n_chk++; if (bus.m_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_T1 got %0b exp 1", bus.m_ready); end
        n_chk++; if (bus.m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata got %h exp deadbeef", bus.m_rdata); end
        n_chk++; if (bus.m_err !== 1'b0) begin n_fail++; $display("FAIL rd_err got %0b exp 0", bus.m_err); end
        n_chk++; if (bus.s_req !== 2'b00) begin n_fail++; $display("FAIL rd_s_req_T1 got %b exp 00", bus.s_req); end
        tick(); bus.m_req = 0; bus.s_ready = 2'b00;
    endtask

    task automatic test_write_wait();
        bus.m_req = 1; bus.m_addr = 32'hFFFF_FFF0; bus.m_wdata = 32'h0000_0003;
        bus.m_byteMask = 4'b0001; bus.m_write = 1; smp();
        n_chk++; if (bus.s_req !== 2'b10) begin n_fail++; $display("FAIL wr_s_req got %b exp 10", bus.s_req); end
        n_chk++; if ({bus.s_write, bus.s_byteMask, bus.s_wdata} !== {1'b1, 4'b0001, 32'h3})
            begin n_fail++; $display("FAIL wr_pass got %b/%b/%h exp 1/0001/00000003", bus.s_write, bus.s_byteMask, bus.s_wdata); end
        for (int i = 1; i <= 2; i++) begin
            tick(); smp();
            n_chk++; if ({bus.s_req, bus.m_ready} !== 3'b000) begin n_fail++; $display("FAIL wr_wait%0d got s_req=%b ready=%0b exp 00/0", i, bus.s_req, bus.m_ready); end
        end
        tick(); bus.s_ready = 2'b10; smp();
        n_chk++; if ({bus.m_ready, bus.m_err} !== 2'b10) begin n_fail++; $display("FAIL wr_done got ready=%0b err=%0b exp 1/0", bus.m_ready, bus.m_err); end
        tick(); bus.m_req = 0; bus.m_write = 0; bus.s_ready = 2'b00;
    endtask

    task automatic test_unmapped();
        bus.m_req = 1; bus.m_addr = 32'h0000_1000; smp();
        n_chk++; if ({bus.s_req, bus.m_ready} !== 3'b000) begin n_fail++; $display("FAIL miss_T got s_req=%b ready=%0b exp 00/0", bus.s_req, bus.m_ready); end
        tick(); bus.m_addr = 32'h0000_2000; smp();
        n_chk++; if ({bus.m_ready, bus.m_err} !== 2'b11) begin n_fail++; $display("FAIL miss_resp got ready=%0b err=%0b exp 1/1", bus.m_ready, bus.m_err); end
        n_chk++; if (bus.m_rdata !== 32'h0) begin n_fail++; $display("FAIL miss_rdata got %h exp 0", bus.m_rdata); end
        tick(); bus.m_req = 0; smp();
        n_chk++; if (bus.err_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL miss_err_addr got %h exp 00001000", bus.err_addr); end
        n_chk++; if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL miss_err_count got %0d exp 1", bus.err_count); end
    endtask

    task automatic test_timeout();
        tick(); bus.m_req = 1; bus.m_addr = 32'h0000_0080; smp();
        n_chk++; if (bus.s_req !== 2'b01) begin n_fail++; $display("FAIL to_s_req got %b exp 01", bus.s_req); end
        for (int i = 1; i <= 4; i++) begin
            tick(); if (i == 1) bus.m_addr = 32'h0000_1234; smp();
            n_chk++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d got ready=%0b exp 0", i, bus.m_ready); end
        end
        tick(); smp();
        n_chk++; if ({bus.m_ready, bus.m_err} !== 2'b11) begin n_fail++; $display("FAIL to_resp got ready=%0b err=%0b exp 1/1", bus.m_ready, bus.m_err); end
        n_chk++; if (bus.m_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h exp 0", bus.m_rdata); end
        tick(); bus.m_req = 0; bus.s_ready = 2'b01; smp();
        n_chk++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL to_late_ready got %0b exp 0", bus.m_ready); end
        n_chk++; if (bus.err_count !== 8'd2) begin n_fail++; $display("FAIL to_err_count got %0d exp 2", bus.err_count); end
        n_chk++; if (bus.err_addr !== 32'h0000_0080) begin n_fail++; $display("FAIL to_err_addr got %h exp 00000080", bus.err_addr); end
        tick(); bus.s_ready = 2'b00;
    endtask

    task automatic test_timeout_boundary();
        bus.m_req = 1; bus.m_addr = 32'h0000_0100; smp();
        for (int i = 1; i <= 4; i++) tick();
        tick(); bus.s_ready = 2'b01; smp();
        n_chk++; if ({bus.m_ready, bus.m_err} !== 2'b10) begin n_fail++; $display("FAIL bnd_resp got ready=%0b err=%0b exp 1/0", bus.m_ready, bus.m_err); end
        n_chk++; if (bus.m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bnd_rdata got %h exp deadbeef", bus.m_rdata); end
        tick(); bus.m_req = 0; bus.s_ready = 2'b00; smp();
        n_chk++; if (bus.err_count !== 8'd2) begin n_fail++; $display("FAIL bnd_err_count got %0d exp 2", bus.err_count); end
    endtask

    task automatic test_back_to_back();
        tick(); bus.s_ready = 2'b01; bus.m_req = 1; bus.m_addr = 32'h0000_0044;
        for (int i = 0; i < 4; i++) begin
            smp();
            n_chk++; if ({bus.s_req, bus.m_ready} !== ((i % 2 == 0) ? 3'b010 : 3'b001))
                begin n_fail++; $display("FAIL b2b_cyc%0d got s_req=%b ready=%0b", i, bus.s_req, bus.m_ready); end
            tick();
        end
        bus.m_req = 0; bus.s_ready = 2'b00;
    endtask

    task automatic test_saturate();
        tick(); bus.m_req = 1; bus.m_addr = 32'h0000_3000;
        for (int i = 0; i < 500; i++) tick();
        smp();
        n_chk++; if (bus.err_count !== 8'd252) begin n_fail++; $display("FAIL sat_mid got %0d exp 252", bus.err_count); end
        for (int i = 0; i < 100; i++) tick();
        bus.m_req = 0; smp();
        n_chk++; if (bus.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_end got %0d exp 255", bus.err_count); end
        n_chk++; if (bus.err_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL sat_err_addr got %h exp 00003000", bus.err_addr); end
    endtask

    task automatic test_reset_mid();
        tick(); bus.m_req = 1; bus.m_addr = 32'h0000_0040; bus.s_ready = 2'b00;
        tick(); reset_n = 0;
        tick(); reset_n = 1; bus.m_req = 0; smp();
        n_chk++; if ({bus.s_req, bus.m_ready, bus.m_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_out got s_req=%b ready=%0b err=%0b exp 0", bus.s_req, bus.m_ready, bus.m_err); end
        n_chk++; if (bus.m_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata got %h exp 0", bus.m_rdata); end
        n_chk++; if ({bus.err_count, bus.err_addr} !== 40'h0) begin n_fail++; $display("FAIL rst_mid_err got %0d/%h exp 0/0", bus.err_count, bus.err_addr); end
        tick(); bus.s_ready = 2'b01; bus.m_req = 1; smp();
        n_chk++; if (bus.s_req !== 2'b01) begin n_fail++; $display("FAIL rst_mid_reissue got %b exp 01", bus.s_req); end
        tick(); smp();
        n_chk++; if ({bus.m_ready, bus.m_err, bus.m_rdata} !== {2'b10, 32'hDEAD_BEEF})
            begin n_fail++; $display("FAIL rst_mid_read got ready=%0b err=%0b rdata=%h exp 1/0/deadbeef", bus.m_ready, bus.m_err, bus.m_rdata); end
        tick(); bus.m_req = 0; bus.s_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_read_bram();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_interconnect.md
# mmio_interconnect

Parametrised memory-mapped bus interconnect between the multicycle CPU's memory port and N MMIO slaves (BRAM, GPIO, future SPI flash, timers). It replaces the ad-hoc address comparator and delayed-address read mux in the SoC top. It adds:
- a per-slave ready handshake (wait states),
- a watchdog timeout,
- bus-error signalling with sticky error capture.

## Interface
Parameters:
- N_SLAVES, 4, number of slave ports (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte mask is DATA_W/8 bits
- SLV_BASE, all zero, packed N_SLAVES*ADDR_W; base address of slave k in bits [k*ADDR_W +: ADDR_W]
- SLV_MASK, all zero, packed N_SLAVES*ADDR_W; slave k hits when (m_addr & mask_k) == (base_k & mask_k)
- TIMEOUT, 15, maximum wait cycles before a bus error; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active low
- m_req  in  1  master access request; held until m_ready
- m_addr  in  ADDR_W  master address
- m_wdata  in  DATA_W  master write data
- m_byteMask  in  DATA_W/8  byte enables
- m_write  in  1  1 = write, 0 = read
- m_rdata  out  DATA_W  read data, valid when m_ready is high
- m_ready  out  1  one-cycle access-complete pulse
- m_err  out  1  bus error; qualified by m_ready
- s_req  out  N_SLAVES  one-hot issue strobe, one cycle per access
- s_addr  out  ADDR_W  m_addr passed through
- s_wdata  out  DATA_W  m_wdata passed through
- s_byteMask  out  DATA_W/8  m_byteMask passed through
- s_write  out  1  m_write passed through; slaves qualify it with s_req[k]
- s_rdata  in  N_SLAVES*DATA_W  packed read data from the slaves
- s_ready  in  N_SLAVES  slave k completes its access
- err_addr  out  ADDR_W  address of the most recent errored access (sticky)
- err_count  out  8  saturating count of bus errors

## Operation
- FSM states:
  - IDLE: the only state in which m_req is sampled.
  - WAIT: access issued; waiting for the slave.
  - MISS: unmapped address.
- Address decode is combinational. When several slaves match, the lowest index wins.
- IDLE with m_req=1 and a hit on slave k:
  - s_req[k]=1 for that cycle only;
  - sel_idx <= k, timeout counter cleared;
  - next state WAIT.
- IDLE with m_req=1 and no hit:
  - all s_req stay 0, so a write is dropped and no slave sees it;
  - next state MISS.
- WAIT:
  - m_rdata = s_rdata[sel_idx] and m_ready = s_ready[sel_idx] (combinational); m_err=0.
  - On m_ready the FSM returns to IDLE.
  - Each cycle without s_ready, the counter increments.
- Timeout: in WAIT, when the counter equals TIMEOUT and s_ready[sel_idx]=0:
  - m_ready=1, m_err=1, m_rdata=0;
  - next state IDLE.
  - Outstanding slave work is abandoned; a later s_ready from that slave is ignored.
- MISS: m_ready=1, m_err=1, m_rdata=0 for one cycle; next state IDLE.
- Every error cycle (m_ready & m_err):
  - err_addr <= address latched at issue;
  - err_count increments and saturates at 255.
- The issue address is latched in IDLE. Master changes to m_addr during WAIT or MISS do not affect steering or err_addr.
- Outside WAIT and MISS: m_ready=0, m_err=0, m_rdata=0.
- s_addr, s_wdata, s_byteMask and s_write pass through combinationally at all times.
- Slave-side assumption: a slave with fixed one-cycle latency (BRAM) ties s_ready high.
- Reset (reset_n=0 at a rising edge, from any state including mid-access):
  - state IDLE, sel_idx 0, counter 0;
  - err_addr 0, err_count 0;
  - m_ready 0, m_err 0, m_rdata 0, s_req 0.
  - No response is generated for an access interrupted by reset.

## Timing
- Issue cycle T: s_req pulses. The earliest m_ready is at T+1, which is single-cycle read latency, matching the existing BRAM behaviour.
- With wait states, m_ready occurs in the first cycle of WAIT in which s_ready[sel_idx]=1.
- Timeout error: m_ready at T+1+TIMEOUT at the latest.
- With TIMEOUT=0, WAIT lasts indefinitely until s_ready.
- Unmapped error: m_ready=1, m_err=1 at T+1.
- Back-to-back: after an m_ready cycle the FSM is in IDLE, so a held or new m_req in the following cycle issues immediately. Throughput is one access per 2 cycles minimum.
- s_ready arriving on the same cycle the counter reaches TIMEOUT: the access succeeds (m_err=0) and the timeout is not taken.
- err_addr and err_count update on the clock edge ending the error cycle.

## Test plan
Bench configuration: N_SLAVES=2; slave0 base 0x0000_0000 mask 0xFFFF_FE00; slave1 base 0xFFFF_FFF0 mask 0xFFFF_FFFC; TIMEOUT=4.

- Read 0x0000_0040 with s_ready[0] tied 1 and s_rdata[0]=0xDEAD_BEEF -> s_req=01 at T; m_ready=1, m_rdata=0xDEAD_BEEF, m_err=0 at T+1.
- Write 0xFFFF_FFF0 with data 0x0000_0003, mask 0001, slave1 asserting s_ready 2 cycles late -> s_req=10 for 1 cycle; m_ready at T+3; no error.
- Read unmapped 0x0000_1000 -> s_req stays 00; m_ready=1, m_err=1, m_rdata=0 at T+1; err_addr=0x0000_1000, err_count=1.
- Read slave0 with s_ready held 0 -> m_ready=1, m_err=1 at T+5; a late s_ready is ignored; err_count increments.
- Boundary cases:
  - s_ready rises exactly at counter==4 -> success, no error.
  - 300 consecutive misses -> err_count saturates at 255.
- reset_n=0 during WAIT -> next cycle state IDLE, all outputs 0, err_count 0; the subsequent read completes normally.
